scu_scheduler: RTL and testbench
================================

# scu_scheduler

Sequences one layer's channel sweep onto the POF×PIF SCU array. Accepts a layer configuration (output and input channel counts) and issues every (out_idx, in_idx) pair exactly once, in order, over a valid/ready handshake. Each pair carries its target SCU row, column and linear index. The block sits between the layer controller and the SCU array's dispatch port, and replaces per-pair division with running group counters.

## Interface
- POF, 4, SCU array rows (output-channel parallelism)
- PIF, 12, SCU array columns (input-channel parallelism)
- IDX_WIDTH, 16, channel index/count width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  layer config offered
- cfg_ready  out  1  high only in IDLE
- cfg_out_ch  in  IDX_WIDTH  output channel count (oc)
- cfg_in_ch  in  IDX_WIDTH  input channel count (ic)
- issue_valid  out  1  pair presented
- issue_ready  in  1  SCU array accepts pair
- issue_out_idx  out  IDX_WIDTH  output channel index o
- issue_in_idx  out  IDX_WIDTH  input channel index i
- issue_scu_row  out  $clog2(POF)  target row
- issue_scu_col  out  $clog2(PIF)  target column
- issue_scu_linear  out  $clog2(POF*PIF)  row*PIF+col
- issue_last  out  1  final pair of the layer
- issue_count  out  2*IDX_WIDTH  pairs accepted since config
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at layer completion

## Operation
- States: IDLE, SETUP, ISSUE, DONE.
- IDLE: cfg_ready=1. On cfg_valid&&cfg_ready, register oc and ic, clear issue_count, go to SETUP.
- SETUP (1 cycle): register opr=ceil(oc/POF) and ipc=ceil(ic/PIF), computed as (x+P-1)/P. Zero all index and group counters. If oc==0 or ic==0, go to DONE. Otherwise go to ISSUE.
- ISSUE: issue_valid=1. All issue_* outputs come straight from registers. The sweep order has in_idx as the inner loop and out_idx as the outer loop.
- Advance happens only on issue_valid&&issue_ready. On each advance, issue_count increments and:
  - in_idx increments.
  - The column sub-counter increments. When it reaches ipc-1 it clears and col increments.
  - When in_idx==ic-1, in_idx, col and the column sub-counter clear to 0, and out_idx advances the row counters the same way, using opr.
- Row and col saturate at POF-1 and PIF-1. This is defensive only; a legal sweep never reaches the limit.
- issue_last=1 when out_idx==oc-1 && in_idx==ic-1. A handshake with issue_last set moves to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
- Required mapping, checked by the bench:
  - row = min(o/opr, POF-1)
  - col = min(i/ipc, PIF-1)
  - linear = row*PIF+col

## Timing
- Reset values: state IDLE, cfg_ready=1, all issue_* outputs 0, issue_count 0, busy 0, done 0.
- Config accepted at cycle k. SETUP runs at k+1. The first issue_valid appears at k+2.
- Zero-size layer: done pulses at k+2 and issue_valid never rises.
- Throughput is 1 pair/cycle while issue_ready=1.
- Hold rule: while issue_valid && !issue_ready, every issue_* output and issue_count stays stable.
- issue_valid never drops without a handshake.
- Final handshake at cycle n:
  - DONE at n+1 (done=1, issue_valid=0).
  - IDLE at n+2, where cfg_ready=1 again.
- cfg_valid is ignored outside IDLE. No config is queued.
- issue_count is not cleared at DONE. It holds the final total until the next config is accepted.
- rst asserted in any state, including mid-ISSUE with a stalled pair: the next cycle shows reset values, and the partial sweep is discarded.

## Structure
- Package scu_pkg holds:
  - the defaults for POF, PIF and IDX_WIDTH
  - the state enum {IDLE, SETUP, ISSUE, DONE}
  - the derived widths ROW_W=$clog2(POF), COL_W=$clog2(PIF), LIN_W=$clog2(POF*PIF)
- One sub-module, scu_axis_counter, is instantiated twice (output axis and input axis). Each instance contains:
  - an index counter with terminal count (size-1)
  - a group sub-counter with terminal count (per-1)
  - a saturating group counter
  - inputs: clear and advance
  - outputs: idx, grp and wrap

## Test plan
- oc=36, ic=36 (opr=9, ipc=3), issue_ready=1:
  - exactly 1296 pairs, then done one cycle after the last handshake
  - (5,10) → row0/col3/lin3
  - (17,20) → row1/col6/lin18
  - (35,35) → row3/col11/lin47 with issue_last=1
  - final issue_count=1296
- oc=1, ic=1: single pair (0,0) → row0/col0/lin0 with issue_last=1; issue_valid rises at k+2; done pulses at k+3.
- oc=0, ic=12: no issue_valid; done at k+2; cfg_ready=1 at k+3.
- oc=11, ic=11 (opr=3, ipc=1), issue_ready randomly deasserted, including 3-cycle stalls:
  - outputs held during stalls
  - (10,10) → row3/col10/lin46
  - all 121 pairs in order, none duplicated
- Reset mid-layer: rst for 1 cycle after 50 handshakes of an oc=36, ic=36 layer → next cycle IDLE with all outputs 0. A new oc=4, ic=12 config then issues 48 pairs, each with row=o and col=i.
- cfg_valid held high throughout a layer: exactly one config accepted per IDLE visit; no acceptance during SETUP, ISSUE or DONE.

Source files
------------

// File: rtl/scu_pkg.sv
// Shared defaults, derived widths and FSM state encoding for the SCU scheduler.
package scu_pkg;

    localparam int POF_DEF       = 4;   // SCU array rows (output-channel parallelism)
    localparam int PIF_DEF       = 12;  // SCU array columns (input-channel parallelism)
    localparam int IDX_WIDTH_DEF = 16;  // channel index / count width

    localparam int ROW_W = $clog2(POF_DEF);
    localparam int COL_W = $clog2(PIF_DEF);
    localparam int LIN_W = $clog2(POF_DEF * PIF_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/scu_axis_counter.sv
// One sweep axis: channel index, group sub-counter and saturating group
// counter. The group counter replaces idx/per division with a running count.
module scu_axis_counter #(
    parameter int IDX_WIDTH = 16,
    parameter int GRP_W     = 2,
    parameter int GRP_MAX   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [IDX_WIDTH-1:0] size,
    input  logic [IDX_WIDTH-1:0] per,
    output logic [IDX_WIDTH-1:0] idx,
    output logic [GRP_W-1:0]     grp,
    output logic [GRP_W-1:0]     grp_nxt,
    output logic                 wrap
);

    localparam logic [IDX_WIDTH-1:0] ONE     = 1;
    localparam logic [GRP_W-1:0]     GRP_ONE = 1;
    localparam logic [GRP_W-1:0]     GRP_TOP = GRP_W'(GRP_MAX);

    logic [IDX_WIDTH-1:0] idx_q, idx_nxt;
    logic [IDX_WIDTH-1:0] sub_q, sub_nxt;
    logic [GRP_W-1:0]     grp_q;

    assign idx  = idx_q;
    assign grp  = grp_q;
    assign wrap = (idx_q == size - ONE);

    // Next index / sub-counter / group; grp_nxt is exported so the parent can
    // register values derived from the group without an extra cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        idx_nxt = idx_q;
        sub_nxt = sub_q;
        grp_nxt = grp_q;
        if (clear) begin
            idx_nxt = '0;
            sub_nxt = '0;
            grp_nxt = '0;
        end else if (advance) begin
            if (wrap) begin
                idx_nxt = '0;
                sub_nxt = '0;
                grp_nxt = '0;
            end else begin
                idx_nxt = idx_q + ONE;
                if (sub_q == per - ONE) begin
                    sub_nxt = '0;
                    // Saturation is defensive; a legal sweep never hits it.
                    if (grp_q != GRP_TOP) begin
                        grp_nxt = grp_q + GRP_ONE;
                    end
                end else begin
                    sub_nxt = sub_q + ONE;
                end
            end
        end
    end

    // Counter state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            idx_q <= '0;
            sub_q <= '0;
            grp_q <= '0;
        end else begin
            idx_q <= idx_nxt;
            sub_q <= sub_nxt;
            grp_q <= grp_nxt;
        end
    end

endmodule

// File: rtl/scu_scheduler.sv
// Sweeps every (out_idx, in_idx) pair of one layer onto the POFxPIF SCU array,
// in_idx inner / out_idx outer, over a valid/ready issue handshake.
module scu_scheduler
    import scu_pkg::*;
#(
    parameter int POF       = POF_DEF,
    parameter int PIF       = PIF_DEF,
    parameter int IDX_WIDTH = IDX_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [IDX_WIDTH-1:0]         cfg_out_ch,
    input  logic [IDX_WIDTH-1:0]         cfg_in_ch,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [IDX_WIDTH-1:0]         issue_out_idx,
    output logic [IDX_WIDTH-1:0]         issue_in_idx,
    output logic [$clog2(POF)-1:0]       issue_scu_row,
    output logic [$clog2(PIF)-1:0]       issue_scu_col,
    output logic [$clog2(POF*PIF)-1:0]   issue_scu_linear,
    output logic                         issue_last,
    output logic [2*IDX_WIDTH-1:0]       issue_count,
    output logic                         busy,
    output logic                         done
);

    localparam int RW    = $clog2(POF);
    localparam int CW    = $clog2(PIF);
    localparam int LW    = $clog2(POF * PIF);
    localparam int CNT_W = 2 * IDX_WIDTH;

    localparam logic [IDX_WIDTH:0] POF_X  = (IDX_WIDTH+1)'(POF);
    localparam logic [IDX_WIDTH:0] PIF_X  = (IDX_WIDTH+1)'(PIF);
    localparam logic [IDX_WIDTH:0] POF_M1 = (IDX_WIDTH+1)'(POF - 1);
    localparam logic [IDX_WIDTH:0] PIF_M1 = (IDX_WIDTH+1)'(PIF - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE = 1;

    state_t state, state_nxt;

    logic [IDX_WIDTH-1:0] oc_q, ic_q, opr_q, ipc_q;
    logic [IDX_WIDTH:0]   oc_sum, ic_sum;
    logic [CNT_W-1:0]     cnt_q;
    logic [LW-1:0]        lin_q, lin_nxt;
    logic [RW-1:0]        row, row_nxt;
    logic [CW-1:0]        col, col_nxt;
    logic                 in_wrap, out_wrap;
    logic                 accept, hs, clear;

    assign accept = cfg_valid && cfg_ready;
    assign hs     = issue_valid && issue_ready;
    assign clear  = (state == SETUP);

    // One spare bit keeps (x+P-1) from overflowing before the divide.
    assign oc_sum  = {1'b0, oc_q} + POF_M1;
    assign ic_sum  = {1'b0, ic_q} + PIF_M1;
    assign lin_nxt = LW'(row_nxt) * LW'(PIF) + LW'(col_nxt);

    scu_axis_counter #(.IDX_WIDTH(IDX_WIDTH), .GRP_W(RW), .GRP_MAX(POF - 1)) u_out_axis (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (hs && in_wrap),
        .size    (oc_q),
        .per     (opr_q),
        .idx     (issue_out_idx),
        .grp     (row),
        .grp_nxt (row_nxt),
        .wrap    (out_wrap)
    );

    scu_axis_counter #(.IDX_WIDTH(IDX_WIDTH), .GRP_W(CW), .GRP_MAX(PIF - 1)) u_in_axis (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (hs),
        .size    (ic_q),
        .per     (ipc_q),
        .idx     (issue_in_idx),
        .grp     (col),
        .grp_nxt (col_nxt),
        .wrap    (in_wrap)
    );

    assign issue_scu_row    = row;
    assign issue_scu_col    = col;
    assign issue_scu_linear = lin_q;
    assign issue_count      = cnt_q;
    assign issue_last       = (state == ISSUE) && in_wrap && out_wrap;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_nxt   = state;
        cfg_ready   = 1'b0;
        issue_valid = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) state_nxt = SETUP;
            end
            SETUP: begin
                if (oc_q == '0 || ic_q == '0) state_nxt = DONE;
                else                          state_nxt = ISSUE;
            end
            ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready && in_wrap && out_wrap) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Layer config, group sizes, accepted-pair count and registered linear index.
    always_ff @(posedge clk) begin
        if (rst) begin
            oc_q  <= '0;
            ic_q  <= '0;
            opr_q <= '0;
            ipc_q <= '0;
            cnt_q <= '0;
            lin_q <= '0;
        end else begin
            if (accept) begin
                oc_q  <= cfg_out_ch;
                ic_q  <= cfg_in_ch;
                cnt_q <= '0;
            end else if (hs) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (state == SETUP) begin
                opr_q <= IDX_WIDTH'(oc_sum / POF_X);
                ipc_q <= IDX_WIDTH'(ic_sum / PIF_X);
            end
            lin_q <= lin_nxt;
        end
    end

endmodule

// File: tb/tb_scu_scheduler.sv
// Scoreboard bench for scu_scheduler: expected pairs are queued when a layer
// config is driven and popped on every issue handshake.
module tb_scu_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_out_ch = '0;
    logic [15:0] cfg_in_ch = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [15:0] issue_out_idx;
    logic [15:0] issue_in_idx;
    logic [1:0]  issue_scu_row;
    logic [3:0]  issue_scu_col;
    logic [5:0]  issue_scu_linear;
    logic        issue_last;
    logic [31:0] issue_count;
    logic        busy;
    logic        done;

    scu_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_out_ch       (cfg_out_ch),
        .cfg_in_ch        (cfg_in_ch),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_out_idx    (issue_out_idx),
        .issue_in_idx     (issue_in_idx),
        .issue_scu_row    (issue_scu_row),
        .issue_scu_col    (issue_scu_col),
        .issue_scu_linear (issue_scu_linear),
        .issue_last       (issue_last),
        .issue_count      (issue_count),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int o;
        int i;
        int row;
        int col;
        int lin;
        bit last;
    } exp_t;

    typedef struct {
        int o;
        int i;
        int row;
        int col;
        int lin;
    } spot_t;

    typedef struct {
        logic [15:0] o;
        logic [15:0] i;
        logic [1:0]  row;
        logic [3:0]  col;
        logic [5:0]  lin;
        logic        last;
        logic [31:0] cnt;
    } obs_t;

    exp_t  sb[$];
    spot_t spots[$];
    int    spot_hits;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready, 1);
        check({tag, "_valid"}, issue_valid, 0);
        check({tag, "_out_idx"}, issue_out_idx, 0);
        check({tag, "_in_idx"}, issue_in_idx, 0);
        check({tag, "_row"}, issue_scu_row, 0);
        check({tag, "_col"}, issue_scu_col, 0);
        check({tag, "_lin"}, issue_scu_linear, 0);
        check({tag, "_last"}, issue_last, 0);
        check({tag, "_count"}, issue_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic add_spot(input int o, input int i, input int row, input int col, input int lin);
        spot_t s;
        s.o = o; s.i = i; s.row = row; s.col = col; s.lin = lin;
        spots.push_back(s);
    endtask

    // Drives one layer config (starting in IDLE) and checks the whole sweep.
    task automatic run_layer(input int oc, input int ic, input bit rnd, input bit hold_cfg,
                             input int abort_after, input bit direct_map);
        int   opr, ipc, total, hs_n, ncy, stall_left;
        bit   fin, held, rdy;
        exp_t e;
        obs_t saved;

        opr   = (oc + 3) / 4;
        ipc   = (ic + 11) / 12;
        total = oc * ic;
        for (int o = 0; o < oc; o++) begin
            for (int i = 0; i < ic; i++) begin
                e.o    = o;
                e.i    = i;
                e.row  = (o / opr > 3) ? 3 : o / opr;
                e.col  = (i / ipc > 11) ? 11 : i / ipc;
                e.lin  = e.row * 12 + e.col;
                e.last = (o == oc - 1) && (i == ic - 1);
                sb.push_back(e);
            end
        end

        check("cfg_ready_idle", cfg_ready, 1);
        cfg_valid   = 1'b1;
        cfg_out_ch  = 16'(oc);
        cfg_in_ch   = 16'(ic);
        issue_ready = 1'b1;
        spot_hits   = 0;
        step();  // cycle k+1: SETUP
        if (!hold_cfg) begin
            cfg_valid  = 1'b0;
            cfg_out_ch = 16'hffff;
            cfg_in_ch  = 16'h0;
        end
        check("setup_valid", issue_valid, 0);
        check("setup_busy", busy, 1);
        check("setup_cfg_ready", cfg_ready, 0);
        check("setup_count_clr", issue_count, 0);
        step();  // cycle k+2

        if (total == 0) begin
            check("zero_done", done, 1);
            check("zero_valid", issue_valid, 0);
            check("zero_cfg_ready", cfg_ready, 0);
            step();
            check("zero_idle_cfg_ready", cfg_ready, 1);
            check("zero_idle_done", done, 0);
            check("zero_idle_valid", issue_valid, 0);
            check("zero_idle_busy", busy, 0);
            check("zero_sb_empty", sb.size(), 0);
            return;
        end

        check("first_valid", issue_valid, 1);
        hs_n = 0; ncy = 0; stall_left = 0; fin = 0; held = 0;
        while (!fin && ncy < 20000) begin
            check("valid_high", issue_valid, 1);
            check("cfg_ready_busy", cfg_ready, 0);
            if (held) begin
                check("hold_out_idx", issue_out_idx, saved.o);
                check("hold_in_idx", issue_in_idx, saved.i);
                check("hold_row", issue_scu_row, saved.row);
                check("hold_col", issue_scu_col, saved.col);
                check("hold_lin", issue_scu_linear, saved.lin);
                check("hold_last", issue_last, saved.last);
                check("hold_count", issue_count, saved.cnt);
            end
            if (!rnd) begin
                rdy = 1'b1;
            end else if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 11) == 0) begin
                rdy = 1'b0;
                stall_left = 2;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            issue_ready = rdy;
            if (rdy) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                    fin = 1'b1;
                end else begin
                    e = sb.pop_front();
                    check("out_idx", issue_out_idx, e.o);
                    check("in_idx", issue_in_idx, e.i);
                    check("row", issue_scu_row, e.row);
                    check("col", issue_scu_col, e.col);
                    check("lin", issue_scu_linear, e.lin);
                    check("last", issue_last, e.last);
                    check("count", issue_count, hs_n);
                    if (direct_map) begin
                        check("direct_row", issue_scu_row, e.o);
                        check("direct_col", issue_scu_col, e.i);
                    end
                    foreach (spots[s]) begin
                        if (issue_out_idx == 16'(spots[s].o) && issue_in_idx == 16'(spots[s].i)) begin
                            spot_hits++;
                            check("spot_row", issue_scu_row, spots[s].row);
                            check("spot_col", issue_scu_col, spots[s].col);
                            check("spot_lin", issue_scu_linear, spots[s].lin);
                        end
                    end
                    hs_n++;
                    fin  = e.last;
                    held = 1'b0;
                end
            end else begin
                saved.o    = issue_out_idx;
                saved.i    = issue_in_idx;
                saved.row  = issue_scu_row;
                saved.col  = issue_scu_col;
                saved.lin  = issue_scu_linear;
                saved.last = issue_last;
                saved.cnt  = issue_count;
                held       = 1'b1;
            end
            step();
            ncy++;
            if (abort_after > 0 && hs_n == abort_after) begin
                issue_ready = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_reset_values("mid_rst");
                sb.delete();
                spots.delete();
                return;
            end
        end
        if (!fin) check("layer_timeout", 0, 1);

        // n+1: DONE
        check("done_pulse", done, 1);
        check("done_valid", issue_valid, 0);
        check("done_cfg_ready", cfg_ready, 0);
        check("done_count", issue_count, total);
        step();
        // n+2: IDLE
        check("idle_cfg_ready", cfg_ready, 1);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", issue_valid, 0);
        check("idle_count_held", issue_count, total);
        check("pairs_issued", hs_n, total);
        check("sb_empty", sb.size(), 0);
        check("spot_hits", spot_hits, spots.size());
        spots.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        check_reset_values("por");
        rst = 1'b0;
        step();
        check_reset_values("idle");

        // Full 36x36 layer with no back-pressure.
        add_spot(5, 10, 0, 3, 3);
        add_spot(17, 20, 1, 6, 18);
        add_spot(35, 35, 3, 11, 47);
        run_layer(36, 36, 1'b0, 1'b0, 0, 1'b0);

        // Single pair.
        add_spot(0, 0, 0, 0, 0);
        run_layer(1, 1, 1'b0, 1'b0, 0, 1'b0);

        // Zero-size layer.
        run_layer(0, 12, 1'b0, 1'b0, 0, 1'b0);

        // Random back-pressure with 3-cycle stalls.
        add_spot(10, 10, 3, 10, 46);
        run_layer(11, 11, 1'b1, 1'b0, 0, 1'b0);

        // Reset mid-layer, then a fresh layer with a one-to-one mapping.
        run_layer(36, 36, 1'b0, 1'b0, 50, 1'b0);
        run_layer(4, 12, 1'b0, 1'b0, 0, 1'b1);

        // cfg_valid held high: one acceptance per IDLE visit.
        run_layer(2, 3, 1'b0, 1'b1, 0, 1'b0);
        run_layer(2, 3, 1'b1, 1'b0, 0, 1'b0);
        step();
        check("final_idle", cfg_ready, 1);
        check("final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
